signed_seq_divider: RTL

- Multi-cycle signed integer divider for the signed divider datapath; successor to the fixed 16-bit two's-complement negation stage.
- Parametrised width; takes dividend/divisor magnitudes internally, runs a restoring shift-subtract loop, and applies sign correction on the result.
- Uses a start/busy/done handshake and flags divide-by-zero.
- Feeds the divider top level and its result register bank.

---
 rtl/signed_seq_divider.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/signed_seq_divider.sv
// signed_seq_divider
//   Multi-cycle signed integer divider using a restoring shift-subtract loop.
//   Operand magnitudes are formed internally; the quotient is truncated toward
//   zero and the remainder takes the sign of the dividend.
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous active-high reset
//     start        request, sampled only while busy=0
//     dividend     signed dividend, captured on the accepted start edge
//     divisor      signed divisor, captured on the accepted start edge
//     busy         high while an operation is in progress
//     done         one-cycle pulse, results valid from this cycle
//     quotient     signed quotient
//     remainder    signed remainder
//     div_by_zero  set with done when the divisor was zero
//
//   Build option
//     SIGNED_DIV_OVF_SAT_EN  when defined, -2^(WIDTH-1) / -1 saturates the
//                            quotient to 2^(WIDTH-1)-1 instead of wrapping.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; outputs hold last result
//   CONV  | convert captured operands to magnitudes, clear partial rem
//   ITER  | one restoring shift-subtract step per cycle, WIDTH cycles
//   FIX   | sign-correct and publish results, pulse done

module signed_seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO  = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sq;
  logic             sr;
  logic             dz;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    // The most-negative value maps onto 2^(WIDTH-1) as an unsigned magnitude.
    return v[WIDTH-1] ? neg(v) : v;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (divisor == ZERO) ? FIX : CONV;
        end
      end
      CONV: state_nxt = ITER;
      ITER: begin
        if (cnt == CNT_ZERO) begin
          state_nxt = FIX;
        end
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step. The partial remainder is always below |divisor|
  // (at most 2^(WIDTH-1)), so the shifted value fits WIDTH bits and the
  // extra top bit of trial is a clean borrow/sign flag.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_abs};
  end

  // Sign correction and special cases for the published result.
  always_comb begin
    q_fix = sq ? neg(quo) : quo;
    r_fix = sr ? neg(rem) : rem;
`ifdef SIGNED_DIV_OVF_SAT_EN
    // Only -2^(WIDTH-1) / -1 yields a positive quotient magnitude with the
    // top bit set; clamp it to the largest positive value.
    if (!sq && quo[WIDTH-1]) begin
      q_fix = {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    // -2^(WIDTH-1) / -1 falls through and wraps to -2^(WIDTH-1).
`endif
    if (dz) begin
      q_fix = '1;
      r_fix = dvd_q;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      sq          <= 1'b0;
      sr          <= 1'b0;
      dz          <= 1'b0;
      dvs_abs     <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_q       <= dividend;
            dvs_q       <= divisor;
            sq          <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sr          <= dividend[WIDTH-1];
            dz          <= (divisor == ZERO);
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
          end
        end
        CONV: begin
          quo     <= mag(dvd_q);
          dvs_abs <= mag(dvs_q);
          rem     <= '0;
          cnt     <= CNT_LAST;
        end
        ITER: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CNT_ONE;
        end
        FIX: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= dz;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
